uart_tx_fifo: RTL and testbench

Parametrised RS232 transmitter with an input FIFO and runtime frame format. It replaces the fixed 8N1 transmitter for new designs. It accepts words over a valid/ready handshake and buffers up to FIFO_DEPTH of them. Each word is serialised LSB-first with optional parity and one or two stop bits, paced by the shared oversampling baud-rate tick generator.

---
 rtl/uart_tx_fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: RS232 transmitter with input FIFO and a runtime frame format.
// Words arrive over a valid/ready handshake, are buffered in a small FIFO and
// serialised LSB-first with optional parity and one or two stop bits. Bit
// timing comes from the shared oversampling baud tick (OVERSAMPLE per bit).
//
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state and
// parity generation. Without it iPARITY_MODE is ignored and every frame is
// START, DATA, STOP.
//
// FSM states:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | line high; pops the FIFO head and latches the frame format
//   S_START  | start bit, line low for OVERSAMPLE ticks
//   S_DATA   | data bit shift_q[0], DBIT bits, LSB first
//   S_PARITY | parity bit (only with UART_TX_PARITY_EN)
//   S_STOP   | line high for one or two bit periods, then done pulse

module uart_tx_fifo #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          iCLK_50,
  input  logic                          iRST,
  input  logic                          iBAUD_RATE_TICK,
  input  logic [DBIT-1:0]               iDATA,
  input  logic                          iVALID,
  output logic                          oREADY,
  input  logic [1:0]                    iPARITY_MODE,
  input  logic                          iSTOP_BITS,
  output logic                          oTX,
  output logic                          oBUSY,
  output logic                          oTX_DONE,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int IW = $clog2(DBIT);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DBIT - 1);
  localparam logic [TW-1:0] LIM1_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] LIM2_M1  = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;

  logic [DBIT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop;

  logic [DBIT-1:0] shift_q, shift_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tick_cnt_q;
  logic [TW-1:0]   limit_m1;
  logic            tick_end;
  logic            stop2_q;
  logic            tx_d, done_d;

`ifdef UART_TX_PARITY_EN
  logic            par_en_q;
  logic            par_bit_q;
`else
  logic            unused_parity_mode;
  assign unused_parity_mode = ^iPARITY_MODE;
`endif

  // FIFO handshake: ready is decoded from the registered occupancy only,
  // so a push can never land on a full FIFO. Pops happen only from IDLE.
  assign oREADY      = (count_q < DEPTH_C);
  assign push        = iVALID && oREADY;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign oFIFO_COUNT = count_q;
  assign oBUSY       = (state_q != S_IDLE);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge iCLK_50) begin
    if (push) mem[wr_ptr_q] <= iDATA;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A bit period ends on the baud tick where the counter reaches limit-1;
  // the second stop bit is folded into one double-length STOP period.
  assign limit_m1 = ((state_q == S_STOP) && stop2_q) ? LIM2_M1 : LIM1_M1;
  assign tick_end = iBAUD_RATE_TICK && (state_q != S_IDLE) &&
                    (tick_cnt_q == limit_m1);

  // Tick counter: advances on baud ticks only, cleared on every state or bit change.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      tick_cnt_q <= '0;
    end else if ((state_d != state_q) || tick_end) begin
      tick_cnt_q <= '0;
    end else if (iBAUD_RATE_TICK && (state_q != S_IDLE)) begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // State register.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_START;
      end
      S_START: begin
        if (tick_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick_end && (idx_q == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register and bit index updates for the coming cycle.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (pop) shift_d = mem[rd_ptr_q];
      end
      S_START: begin
        if (tick_end) idx_d = '0;
      end
      S_DATA: begin
        if (tick_end) begin
          shift_d = shift_q >> 1;
          if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the frame format is captured only when a word is popped.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      shift_q   <= '0;
      idx_q     <= '0;
      stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      if (pop) begin
        stop2_q   <= iSTOP_BITS;
`ifdef UART_TX_PARITY_EN
        // Reserved mode 11 behaves like no parity.
        par_en_q  <= (iPARITY_MODE == 2'b01) || (iPARITY_MODE == 2'b10);
        par_bit_q <= (^mem[rd_ptr_q]) ^ (iPARITY_MODE == 2'b10);
`endif
      end
    end
  end

  // Output decode from the next state, so the registered line changes on the
  // same edge that enters each state or bit.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_q;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Registered line and done pulse; reset forces the line high at once.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      oTX      <= 1'b1;
      oTX_DONE <= 1'b0;
    end else begin
      oTX      <= tx_d;
      oTX_DONE <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with default parameters
// (DBIT=8, OVERSAMPLE=16, FIFO_DEPTH=4). Parity expectations follow the
// UART_TX_PARITY_EN build option.

module tb_uart_tx_fifo;

  logic       iCLK_50;
  logic       iRST;
  logic       iBAUD_RATE_TICK;
  logic [7:0] iDATA;
  logic       iVALID;
  logic       oREADY;
  logic [1:0] iPARITY_MODE;
  logic       iSTOP_BITS;
  logic       oTX;
  logic       oBUSY;
  logic       oTX_DONE;
  logic [2:0] oFIFO_COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .DBIT(8),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(4)
  ) dut (
    .iCLK_50(iCLK_50),
    .iRST(iRST),
    .iBAUD_RATE_TICK(iBAUD_RATE_TICK),
    .iDATA(iDATA),
    .iVALID(iVALID),
    .oREADY(oREADY),
    .iPARITY_MODE(iPARITY_MODE),
    .iSTOP_BITS(iSTOP_BITS),
    .oTX(oTX),
    .oBUSY(oBUSY),
    .oTX_DONE(oTX_DONE),
    .oFIFO_COUNT(oFIFO_COUNT)
  );

  initial iCLK_50 = 1'b0;
  always #10 iCLK_50 = ~iCLK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge iCLK_50);
    #1;
  endtask

  // Steps until the line goes low (START entry), bounded.
  task automatic wait_start(output int n);
    n = 0;
    while (oTX !== 1'b0 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic push_word(input string name, input logic [7:0] d);
    iDATA  = d;
    iVALID = 1'b1;
    n_checks++;
    if (oREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b, expected 1", name, oREADY);
    end
    step();
    iVALID = 1'b0;
  endtask

  // Called at the first sample after START entry, with a tick every cycle.
  // Returns at the first sample after the final stop edge.
  task automatic run_frame(input string name, input logic [7:0] data,
                           input bit has_par, input bit par_val,
                           input int stop_len);
    int bad;
    int dones;
    dones = 0;
    bad   = 0;
    for (int c = 0; c < 16; c++) begin
      if (oTX !== 1'b0 || oBUSY !== 1'b1) bad++;
      if (oTX_DONE !== 1'b0) dones++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s start: %0d bad cycles, expected 0", name, bad);
    end
    bad = 0;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < 16; c++) begin
        if (oTX !== data[b] || oBUSY !== 1'b1) bad++;
        if (oTX_DONE !== 1'b0) dones++;
        step();
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s data 0x%02h: %0d bad cycles, expected 0", name, data, bad);
    end
    if (has_par) begin
      bad = 0;
      for (int c = 0; c < 16; c++) begin
        if (oTX !== par_val || oBUSY !== 1'b1) bad++;
        if (oTX_DONE !== 1'b0) dones++;
        step();
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL %s parity %b: %0d bad cycles, expected 0", name, par_val, bad);
      end
    end
    bad = 0;
    for (int c = 0; c < stop_len; c++) begin
      if (oTX !== 1'b1 || oBUSY !== 1'b1) bad++;
      if (oTX_DONE !== 1'b0) dones++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s stop %0d: %0d bad cycles, expected 0", name, stop_len, bad);
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL %s early_done: %0d pulses in frame, expected 0", name, dones);
    end
    n_checks++;
    if (oTX_DONE !== 1'b1 || oBUSY !== 1'b0 || oTX !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: done=%b busy=%b tx=%b, expected 1 0 1",
               name, oTX_DONE, oBUSY, oTX);
    end
  endtask

  task automatic send_frame(input string name, input logic [7:0] d,
                            input logic [1:0] mode, input logic stop2,
                            input bit has_par, input bit par_val);
    int n;
    iPARITY_MODE = mode;
    iSTOP_BITS   = stop2;
    push_word(name, d);
    wait_start(n);
    n_checks++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL %s latency: %0d cycles, expected 1", name, n);
    end
    run_frame(name, d, has_par, par_val, stop2 ? 32 : 16);
  endtask

  task automatic test_reset();
    iRST   = 1'b1;
    iVALID = 1'b1;
    iDATA  = 8'hAA;
    iBAUD_RATE_TICK = 1'b1;
    iPARITY_MODE = 2'b00;
    iSTOP_BITS   = 1'b0;
    repeat (3) step();
    n_checks++;
    if (oTX !== 1'b1 || oBUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_line: tx=%b busy=%b, expected 1 0", oTX, oBUSY);
    end
    n_checks++;
    if (oREADY !== 1'b1 || oFIFO_COUNT !== 3'd0 || oTX_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fifo: ready=%b count=%0d done=%b, expected 1 0 0",
               oREADY, oFIFO_COUNT, oTX_DONE);
    end
    iRST   = 1'b0;
    iVALID = 1'b0;
    step();
    n_checks++;
    if (oFIFO_COUNT !== 3'd0 || oTX !== 1'b1 || oBUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: count=%0d tx=%b busy=%b, expected 0 1 0",
               oFIFO_COUNT, oTX, oBUSY);
    end
  endtask

  task automatic test_8n1();
    int n;
    iBAUD_RATE_TICK = 1'b1;
    push_word("8n1", 8'h55);
    n_checks++;
    if (oFIFO_COUNT !== 3'd1 || oBUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1 after_push: count=%0d busy=%b, expected 1 0", oFIFO_COUNT, oBUSY);
    end
    wait_start(n);
    n_checks++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL 8n1 latency: %0d cycles, expected 1", n);
    end
    n_checks++;
    if (oFIFO_COUNT !== 3'd0 || oBUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL 8n1 popped: count=%0d busy=%b, expected 0 1", oFIFO_COUNT, oBUSY);
    end
    run_frame("8n1", 8'h55, 1'b0, 1'b0, 16);
    step();
    n_checks++;
    if (oTX_DONE !== 1'b0 || oTX !== 1'b1) begin
      n_fail++;
      $display("FAIL 8n1 done_width: done=%b tx=%b, expected 0 1", oTX_DONE, oTX);
    end
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    send_frame("par_even", 8'h07, 2'b01, 1'b0, 1'b1, 1'b1);
    send_frame("par_odd",  8'h07, 2'b10, 1'b0, 1'b1, 1'b0);
    send_frame("par_stop2", 8'h07, 2'b01, 1'b1, 1'b1, 1'b1);
    send_frame("par_rsvd", 8'h07, 2'b11, 1'b0, 1'b0, 1'b0);
`else
    send_frame("nopar_mode01", 8'h07, 2'b01, 1'b0, 1'b0, 1'b0);
    send_frame("nopar_stop2",  8'h07, 2'b00, 1'b1, 1'b0, 1'b0);
`endif
    iPARITY_MODE = 2'b00;
    iSTOP_BITS   = 1'b0;
  endtask

  task automatic test_format_change();
    int n;
    iPARITY_MODE = 2'b00;
    iSTOP_BITS   = 1'b0;
    push_word("fmt_a", 8'hA3);
    push_word("fmt_b", 8'h3C);
    wait_start(n);
    n_checks++;
    if (n !== 0) begin
      n_fail++;
      $display("FAIL fmt latency: %0d cycles, expected 0", n);
    end
    fork
      run_frame("fmt_first", 8'hA3, 1'b0, 1'b0, 16);
      begin
        repeat (40) @(negedge iCLK_50);
        iPARITY_MODE = 2'b01;
      end
    join
    wait_start(n);
    n_checks++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL fmt gap: %0d cycles, expected 1", n);
    end
`ifdef UART_TX_PARITY_EN
    run_frame("fmt_second", 8'h3C, 1'b1, 1'b0, 16);
`else
    run_frame("fmt_second", 8'h3C, 1'b0, 1'b0, 16);
`endif
    iPARITY_MODE = 2'b00;
  endtask

  task automatic test_fifo_full();
    int n;
    int bad;
    logic exp_rdy;
    iBAUD_RATE_TICK = 1'b0;
    for (int i = 0; i < 6; i++) begin
      iDATA   = 8'(i);
      iVALID  = 1'b1;
      exp_rdy = (i < 5);
      n_checks++;
      if (oREADY !== exp_rdy) begin
        n_fail++;
        $display("FAIL fifo ready word %0d: got %b, expected %b", i, oREADY, exp_rdy);
      end
      step();
    end
    iVALID = 1'b0;
    repeat (5) step();
    n_checks++;
    if (oFIFO_COUNT !== 3'd4 || oTX !== 1'b0 || oBUSY !== 1'b1 || oREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo stalled: count=%0d tx=%b busy=%b ready=%b, expected 4 0 1 0",
               oFIFO_COUNT, oTX, oBUSY, oREADY);
    end
    iBAUD_RATE_TICK = 1'b1;
    run_frame("fifo_w0", 8'd0, 1'b0, 1'b0, 16);
    for (int w = 1; w < 5; w++) begin
      wait_start(n);
      n_checks++;
      if (n !== 1) begin
        n_fail++;
        $display("FAIL fifo gap before word %0d: %0d cycles, expected 1", w, n);
      end
      run_frame("fifo_wn", 8'(w), 1'b0, 1'b0, 16);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (oTX !== 1'b1 || oBUSY !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || oFIFO_COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL fifo drained: %0d bad cycles count=%0d, expected 0 0", bad, oFIFO_COUNT);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    iBAUD_RATE_TICK = 1'b1;
    push_word("rst_w0", 8'h00);
    push_word("rst_w1", 8'h11);
    push_word("rst_w2", 8'h22);
    n_checks++;
    if (oFIFO_COUNT !== 3'd2 || oBUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL rst queued: count=%0d busy=%b, expected 2 1", oFIFO_COUNT, oBUSY);
    end
    repeat (48) step();
    n_checks++;
    if (oTX !== 1'b0) begin
      n_fail++;
      $display("FAIL rst in_data: tx=%b, expected 0", oTX);
    end
    @(negedge iCLK_50);
    iRST = 1'b1;
    #1;
    n_checks++;
    if (oTX !== 1'b1 || oFIFO_COUNT !== 3'd0 || oBUSY !== 1'b0 || oTX_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL rst async: tx=%b count=%0d busy=%b done=%b, expected 1 0 0 0",
               oTX, oFIFO_COUNT, oBUSY, oTX_DONE);
    end
    step();
    iRST = 1'b0;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (oTX !== 1'b1 || oTX_DONE !== 1'b0 || oBUSY !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || oFIFO_COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL rst quiet: %0d bad cycles count=%0d, expected 0 0", bad, oFIFO_COUNT);
    end
  endtask

  initial begin
    iRST            = 1'b1;
    iVALID          = 1'b0;
    iDATA           = 8'h00;
    iBAUD_RATE_TICK = 1'b0;
    iPARITY_MODE    = 2'b00;
    iSTOP_BITS      = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_format_change();
    test_fifo_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
